// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port,
// redirect request and decode-side valid/ready handshake.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output instr_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  instr_pc_plus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: word-aligned PC feeding a 2-entry
// {pc, instr} buffer toward decode, with redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc0_q, pc0_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d;
  logic [31:0] ins1_q, ins1_d;
  logic        pop;
  logic        push;
  logic        slot1;

  // Handshake decode: pop on accept, push whenever a slot frees up.
  always_comb begin
    pop   = (cnt_q != 2'd0) && bus.instr_ready;
    push  = !bus.redirect_valid && ((cnt_q != 2'd2) || pop);
    slot1 = (cnt_q - {1'b0, pop}) == 2'd1;
  end

  // Next state: redirect flushes; otherwise shift on pop, write tail on push.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    pc0_d  = pc0_q;
    pc1_d  = pc1_q;
    ins0_d = ins0_q;
    ins1_d = ins1_q;
    if (bus.redirect_valid) begin
      cnt_d = 2'd0;
      pc_d  = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
      end
      if (push) begin
        if (slot1) begin
          pc1_d  = pc_q;
          ins1_d = bus.imem_rd;
        end else begin
          pc0_d  = pc_q;
          ins0_d = bus.imem_rd;
        end
        pc_d = pc_q + 32'd4;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RST_PC;
      cnt_q  <= 2'd0;
      pc0_q  <= 32'd0;
      pc1_q  <= 32'd0;
      ins0_q <= 32'd0;
      ins1_q <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      pc0_q  <= pc0_d;
      pc1_q  <= pc1_d;
      ins0_q <= ins0_d;
      ins1_q <= ins1_d;
    end
  end

  // Outputs come straight from the PC and the head entry.
  always_comb begin
    bus.imem_addr      = pc_q;
    bus.instr_valid    = cnt_q != 2'd0;
    bus.instr          = ins0_q;
    bus.instr_pc       = pc0_q;
    bus.instr_pc_plus4 = pc0_q + 32'd4;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue model of the
// fetched stream is checked by a negedge monitor.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  ent_t        exp_q[$];
  logic [31:0] mpc = RPC;
  bit          popped = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0062_E233;
      32'h4:   return 32'h0052_0533;
      32'h8:   return 32'h00A0_2023;
      default: return (a * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mpc    = RPC;
    popped = 0;
  endtask

  // Model of one rising edge: fetched words form a program-order
  // stream from the last redirect target, at most 2 waiting.
  task automatic model_edge();
    int  cnt;
    bit  took;
    if (!rst) return;
    took   = popped;
    cnt    = exp_q.size() + (took ? 1 : 0);
    popped = 0;
    if (bus.redirect_valid) begin
      exp_q.delete();
      mpc = {bus.redirect_pc[31:2], 2'b00};
    end else if (cnt < 2 || took) begin
      exp_q.push_back('{pc: mpc, ins: mem_word(mpc)});
      mpc = mpc + 32'd4;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Monitor: compare presented head against the expected queue.
  always @(negedge clk) begin
    chk("mon_valid", {31'd0, bus.instr_valid},
        {31'd0, exp_q.size() != 0});
    chk("mon_addr", bus.imem_addr, mpc);
    if (exp_q.size() != 0) begin
      chk("mon_instr", bus.instr, exp_q[0].ins);
      chk("mon_pc", bus.instr_pc, exp_q[0].pc);
      chk("mon_pc4", bus.instr_pc_plus4, exp_q[0].pc + 32'd4);
      if (bus.instr_ready) begin
        void'(exp_q.pop_front());
        popped = 1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, RPC);
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.instr_ready    = 1'b0;
    #1;
    chk("rst0_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst0_addr", bus.imem_addr, RPC);
    cycle();
    cycle();
    rst = 1'b1;

    // Streaming
    bus.instr_ready = 1'b1;
    cycle();
    chk("s0_instr", bus.instr, 32'h0062_E233);
    chk("s0_pc", bus.instr_pc, 32'h0);
    cycle();
    chk("s1_instr", bus.instr, 32'h0052_0533);
    chk("s1_pc", bus.instr_pc, 32'h4);
    cycle();
    chk("s2_instr", bus.instr, 32'h00A0_2023);
    chk("s2_pc", bus.instr_pc, 32'h8);

    // Backpressure
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (5) cycle();
    chk("bp_addr", bus.imem_addr, 32'h8);
    chk("bp_instr", bus.instr, 32'h0062_E233);
    bus.instr_ready = 1'b1;
    cycle();
    chk("bp_pc1", bus.instr_pc, 32'h4);
    cycle();
    chk("bp_pc2", bus.instr_pc, 32'h8);

    // Redirect with buffer full
    bus.instr_ready = 1'b0;
    repeat (3) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rd_addr", bus.imem_addr, 32'h10);
    cycle();
    chk("rd_pc", bus.instr_pc, 32'h10);
    chk("rd_pc4", bus.instr_pc_plus4, 32'h14);

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h13;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("mis_addr", bus.imem_addr, 32'h10);

    // Back-to-back redirects
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    cycle();
    bus.redirect_pc    = 32'h200;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("b2b_addr", bus.imem_addr, 32'h200);
    cycle();
    chk("b2b_pc", bus.instr_pc, 32'h200);

    // Wrap
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wr_pc0", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.instr_pc_plus4, 32'h0);
    cycle();
    chk("wr_pc1", bus.instr_pc, 32'h0);

    // Async reset with buffer full, between edges
    bus.instr_ready = 1'b0;
    repeat (3) cycle();
    chk("ar_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        bus.instr_ready    = $urandom_range(0, 9) < 7;
        bus.redirect_valid = $urandom_range(0, 9) == 0;
        bus.redirect_pc    = $urandom;
        cycle();
      end
    end
    bus.redirect_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_addr  output  32  byte address driven to instruction memory A.
REQ-005 SHALL have port imem_rd  input  32  instruction word returned combinationally (same cycle) from instruction memory RD.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target address.
REQ-008 SHALL have port instr_valid  output  1  head buffer entry valid toward decode.
REQ-009 SHALL have port instr_ready  input  1  decode accepts head entry.
REQ-010 SHALL have port instr  output  32  instruction word of head entry.
REQ-011 SHALL have port instr_pc  output  32  address of head entry.
REQ-012 SHALL have port instr_pc_plus4  output  32  instr_pc + 4, modulo 2^32.

Function
REQ-013 SHALL hold a 32-bit fetch PC register; imem_addr SHALL equal the PC register at all times.
REQ-014 SHALL hold a 2-entry FIFO of {pc, instr} pairs plus a 2-bit occupancy count (0..2); instr, instr_pc, instr_pc_plus4 driven from head entry.
REQ-015 SHALL assert instr_valid iff count != 0; outputs are don't-care when instr_valid = 0.
REQ-016 pop SHALL occur when instr_valid && instr_ready.
REQ-017 push SHALL occur when redirect_valid = 0 and (count < 2 or pop); push writes {PC, imem_rd} to tail and PC <= PC + 4.
REQ-018 With no push, PC SHALL hold its value (fetch stall while FIFO full and no pop).
REQ-019 Simultaneous push and pop at count = 2 SHALL keep count = 2, preserving order; at count = 1 keep count = 1 with new entry becoming head next cycle.
REQ-020 redirect_valid = 1 SHALL take priority: FIFO cleared (count <= 0), no push, PC <= {redirect_pc[31:2], 2'b00}; a pop in the same cycle is acknowledged but irrelevant.
REQ-021 Redirect latency: redirect at edge N -> imem_addr = target during cycle N+1 -> target entry valid (instr_valid = 1, instr_pc = target) in cycle N+2 absent further redirect.
REQ-022 Back-to-back redirects SHALL each override; only the last target is fetched.
REQ-023 PC increment SHALL wrap 32'hFFFFFFFC -> 32'h00000000 without flag.
REQ-024 PC SHALL always be word-aligned (bits [1:0] = 0); RESET_PC[1:0] SHALL be forced to 0.
REQ-025 FIFO order SHALL be strictly program order; no entry dropped or duplicated except by redirect clear.

Reset
REQ-026 rst = 0 SHALL immediately (no clock needed) set PC = RESET_PC, count = 0, instr_valid = 0, imem_addr = RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all FIFO contents and any pending redirect.
REQ-028 After rst deasserts, first push SHALL occur at first rising edge; instr_valid = 1 with instr_pc = RESET_PC in the following cycle.

Verification
REQ-029 Streaming: memory 0x0062E233@0, 0x00520533@4, 0x00A02023@8, instr_ready = 1 -> instr sequence 0x0062E233, 0x00520533, 0x00A02023 on consecutive cycles with instr_pc 0, 4, 8.
REQ-030 Backpressure: instr_ready = 0 for 5 cycles after reset -> count reaches 2, imem_addr holds 8, instr stays 0x0062E233; release -> entries 0, 4, 8 delivered in order, none lost.
REQ-031 Redirect: redirect_valid = 1, redirect_pc = 32'h00000010 with FIFO full -> instr_valid = 0 next cycle, imem_addr = 0x10, then instr_pc = 0x10, instr_pc_plus4 = 0x14.
REQ-032 Misaligned redirect: redirect_pc = 32'h00000013 -> imem_addr = 0x10.
REQ-033 Wrap: redirect_pc = 32'hFFFFFFFC, ready = 1 -> instr_pc 0xFFFFFFFC then 0x00000000; instr_pc_plus4 of first = 0x00000000.
REQ-034 Async reset: drive rst = 0 between clock edges with count = 2 -> instr_valid = 0 and imem_addr = RESET_PC before next edge.
